ym_serial_rx: RTL
=================

// Module: ym_serial_rx
// PURPOSE
//  Deserialiser for the YMF262 serial DAC stream (ym_dclk/ym_data/ym_smp) inside the karabas_opl3 CPLD.
//  Oversamples the stream in the clk28 domain and rebuilds signed left/right sample words.
//  Sits directly upstream of the I2S DAC serialiser that drives dac_bck/dac_lrck/dac_dat.
// PARAMETERS
//  WORD_BITS    16    sample width; also the exact dclk count required per channel word
//  SYNC_STAGES  2     synchroniser flops on each YM input (>=2)
//  TIMEOUT      4096  clk28 cycles without a dclk rising edge before loss-of-lock
// PORTS
//  clk28      in   1          28 MHz system clock; the only clock
//  n_rst      in   1          reset, asynchronous, active-low
//  ym_dclk    in   1          YMF262 bit clock, asynchronous to clk28
//  ym_data    in   1          YMF262 serial data, MSB first, valid at dclk rising edge
//  ym_smp     in   2          [0]=SMPAC (left word end), [1]=SMPBD (right word end)
//  smp_l      out  WORD_BITS  last complete left sample, two's complement
//  smp_r      out  WORD_BITS  last complete right sample, two's complement
//  smp_valid  out  1          one-cycle pulse: new smp_l/smp_r pair presented
//  frame_err  out  1          one-cycle pulse: word end seen with bit count != WORD_BITS
//  locked     out  1          stream healthy
// BEHAVIOUR
//  Reset: smp_l=smp_r=0, smp_valid=0, frame_err=0, locked=0, shift reg=0, bit_cnt=0, pend_l=0, timer=0.
//  All YM inputs pass SYNC_STAGES flops; dclk/smp[0]/smp[1] add an edge-detect flop.
//  dclk rise (detected): shift <= {shift[WORD_BITS-2:0], data_sync}; bit_cnt++ (saturates at WORD_BITS+1).
//  smp[0] fall: if bit_cnt==WORD_BITS -> hold_l<=shift, pend_l<=1; else frame_err pulse, pend_l<=0.
//    bit_cnt<=0 in either case.
//  smp[1] fall: if bit_cnt==WORD_BITS and pend_l -> smp_l<=hold_l, smp_r<=shift, smp_valid pulse,
//    pend_l<=0, locked<=1.
//    bit_cnt!=WORD_BITS -> frame_err pulse, no output update, pend_l<=0.
//    Good count but pend_l=0 (right without left) -> word dropped silently, no err.
//    bit_cnt<=0 in all cases.
//  Latency: smp[1] falling at pin -> smp_valid high after SYNC_STAGES+2 clk28 cycles.
//    smp_l/smp_r change in the same cycle smp_valid is high and hold until the next pair.
//  Simultaneous dclk rise and smp fall in one cycle: the latch uses shift before the new bit;
//    the new bit is shifted in and counts toward the next word (bit_cnt<=1).
//  Both smp falls in one cycle: left processed first, so both channels latch the same word;
//    valid if count==WORD_BITS.
//  Second left word before a right: hold_l is overwritten (newest wins), no error.
//  Watchdog: timer resets on every dclk rise and otherwise counts.
//    At TIMEOUT: locked<=0, smp_l<=0, smp_r<=0, pend_l<=0, bit_cnt<=0.
//    Timer saturates; no smp_valid is produced while dclk is idle.
//  frame_err does not clear locked; only the watchdog or reset clears it.
//  n_rst asserted mid-word: immediate return to reset values; first word after release counts from 0.
// STRUCTURE
//  Shared include karabas_opl3_defs.vh holds YM_WORD_BITS (16) and YM_TIMEOUT (4096),
//    the source of the parameter defaults.
//  Sub-module sync_edge: SYNC_STAGES synchroniser plus optional rise/fall detect.
//    Instanced for dclk, smp[0], smp[1], and for data with detect unused.
//  Top level: shift reg + bit counter, pending/hold logic, output regs, watchdog.
// TESTING
//  1. Left 0x1234 then right 0xFEDC, 16 dclks each -> smp_l=0x1234, smp_r=0xFEDC,
//     one smp_valid pulse, locked=1.
//  2. Left word with 15 dclks -> frame_err pulse; the following right word gives no smp_valid;
//     outputs keep prior values.
//  3. Hold dclk low 4096 clk28 cycles after test 1 -> locked=0, smp_l=smp_r=0 at cycle 4096, not before.
//  4. dclk rise and smp[0] fall in the same clk28 cycle -> left word excludes the new bit;
//     next word's bit_cnt starts at 1.
//  5. n_rst low after 8 bits of a left word, then release and send a full pair 0x8000/0x7FFF ->
//     exactly that pair output, no frame_err.
//  6. Random dclk phase vs clk28 (dclk 3.58 MHz), 1000 frames -> scoreboard matches every pair,
//     zero frame_err.

Source files
------------

// File: rtl/ym_serial_rx_pkg.sv
// rtl/ym_serial_rx_pkg.sv - shared constants and types for the YMF262 serial receiver
`timescale 1ns/1ps
package ym_serial_rx_pkg;

   localparam int YM_WORD_BITS   = 16;
   localparam int YM_TIMEOUT     = 4096;
   localparam int YM_SYNC_STAGES = 2;

   // Bit positions inside ym_smp
   localparam int SMP_L = 0;
   localparam int SMP_R = 1;

   typedef struct packed {
      logic dclk_rise;
      logic data;
      logic l_end;
      logic r_end;
   } ym_evt_t;

endpackage

// File: rtl/ym_serial_rx_sync_edge.sv
// rtl/ym_serial_rx_sync_edge.sv - multi-flop synchroniser with optional registered edge detect
`timescale 1ns/1ps
module ym_serial_rx_sync_edge #(
   parameter int STAGES = 2,
   parameter bit DETECT = 1'b1
) (
   input  logic clk28,
   input  logic n_rst,
   input  logic din,
   output logic q,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clk28 or negedge n_rst) begin
      if (!n_rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         prev_q <= sync_q[STAGES-1];
      end
   end

   // q is taken from the edge flop so the level lines up with rise/fall
   assign q = prev_q;

   generate
      if (DETECT) begin : g_detect
         logic rise_q;
         logic fall_q;

         always_ff @(posedge clk28 or negedge n_rst) begin
            if (!n_rst) begin
               rise_q <= 1'b0;
               fall_q <= 1'b0;
            end else begin
               rise_q <= sync_q[STAGES-1] & ~prev_q;
               fall_q <= ~sync_q[STAGES-1] & prev_q;
            end
         end

         assign rise = rise_q;
         assign fall = fall_q;
      end else begin : g_no_detect
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/ym_serial_rx.sv
// rtl/ym_serial_rx.sv - YMF262 serial DAC stream deserialiser to signed left/right samples
`timescale 1ns/1ps
module ym_serial_rx
   import ym_serial_rx_pkg::*;
#(
   parameter int WORD_BITS   = YM_WORD_BITS,
   parameter int SYNC_STAGES = YM_SYNC_STAGES,
   parameter int TIMEOUT     = YM_TIMEOUT
) (
   input  logic                 clk28,
   input  logic                 n_rst,
   input  logic                 ym_dclk,
   input  logic                 ym_data,
   input  logic [1:0]           ym_smp,
   output logic [WORD_BITS-1:0] smp_l,
   output logic [WORD_BITS-1:0] smp_r,
   output logic                 smp_valid,
   output logic                 frame_err,
   output logic                 locked
);

   localparam int CW = $clog2(WORD_BITS + 2);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(WORD_BITS);
   localparam logic [CW-1:0] CNT_SAT  = CW'(WORD_BITS + 1);
   localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);

   logic       dclk_rise, l_end, r_end, data_s;
   logic [2:0] lvl_unused;
   logic [4:0] edge_unused;
   ym_evt_t    ev;

   ym_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .DETECT(1'b1)) u_dclk (
      .clk28(clk28), .n_rst(n_rst), .din(ym_dclk),
      .q(lvl_unused[0]), .rise(dclk_rise), .fall(edge_unused[0])
   );

   ym_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .DETECT(1'b1)) u_smp_l (
      .clk28(clk28), .n_rst(n_rst), .din(ym_smp[SMP_L]),
      .q(lvl_unused[1]), .rise(edge_unused[1]), .fall(l_end)
   );

   ym_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .DETECT(1'b1)) u_smp_r (
      .clk28(clk28), .n_rst(n_rst), .din(ym_smp[SMP_R]),
      .q(lvl_unused[2]), .rise(edge_unused[2]), .fall(r_end)
   );

   ym_serial_rx_sync_edge #(.STAGES(SYNC_STAGES), .DETECT(1'b0)) u_data (
      .clk28(clk28), .n_rst(n_rst), .din(ym_data),
      .q(data_s), .rise(edge_unused[3]), .fall(edge_unused[4])
   );

   assign ev = '{dclk_rise: dclk_rise, data: data_s, l_end: l_end, r_end: r_end};

   logic [WORD_BITS-1:0] shift_q, shift_n, hold_q, hold_n, smp_l_n, smp_r_n;
   logic [CW-1:0]        bit_cnt_q, bit_cnt_n;
   logic [TW-1:0]        timer_q, timer_n;
   logic                 pend_q, pend_n, valid_n, err_n, locked_n, cnt_ok;

   always_comb begin
      shift_n   = shift_q;
      hold_n    = hold_q;
      bit_cnt_n = bit_cnt_q;
      timer_n   = timer_q;
      pend_n    = pend_q;
      smp_l_n   = smp_l;
      smp_r_n   = smp_r;
      locked_n  = locked;
      valid_n   = 1'b0;
      err_n     = 1'b0;
      cnt_ok    = (bit_cnt_q == CNT_FULL);

      if (ev.dclk_rise) begin
         shift_n = {shift_q[WORD_BITS-2:0], ev.data};
         timer_n = '0;
         if (bit_cnt_q != CNT_SAT) bit_cnt_n = bit_cnt_q + 1'b1;
      end else if (timer_q != TMAX) begin
         timer_n = timer_q + 1'b1;
      end

      // Word ends latch the pre-shift register; a coincident new bit starts the next word
      if (ev.l_end) begin
         if (cnt_ok) begin
            hold_n = shift_q;
            pend_n = 1'b1;
         end else begin
            err_n  = 1'b1;
            pend_n = 1'b0;
         end
      end

      if (ev.r_end) begin
         if (cnt_ok && pend_n) begin
            smp_l_n  = hold_n;
            smp_r_n  = shift_q;
            valid_n  = 1'b1;
            locked_n = 1'b1;
         end else if (!cnt_ok) begin
            err_n = 1'b1;
         end
         pend_n = 1'b0;
      end

      if (ev.l_end || ev.r_end) bit_cnt_n = {{(CW-1){1'b0}}, ev.dclk_rise};

      if (timer_n == TMAX) begin
         locked_n  = 1'b0;
         smp_l_n   = '0;
         smp_r_n   = '0;
         pend_n    = 1'b0;
         bit_cnt_n = '0;
         valid_n   = 1'b0;
      end
   end

   always_ff @(posedge clk28 or negedge n_rst) begin
      if (!n_rst) begin
         shift_q   <= '0;
         hold_q    <= '0;
         bit_cnt_q <= '0;
         timer_q   <= '0;
         pend_q    <= 1'b0;
         smp_l     <= '0;
         smp_r     <= '0;
         smp_valid <= 1'b0;
         frame_err <= 1'b0;
         locked    <= 1'b0;
      end else begin
         shift_q   <= shift_n;
         hold_q    <= hold_n;
         bit_cnt_q <= bit_cnt_n;
         timer_q   <= timer_n;
         pend_q    <= pend_n;
         smp_l     <= smp_l_n;
         smp_r     <= smp_r_n;
         smp_valid <= valid_n;
         frame_err <= err_n;
         locked    <= locked_n;
      end
   end

endmodule
